// File: rtl/mmc3_bank_irq_core.sv
// MMC3-family core: register file, PRG/CHR banking, CHR-RAM overlay and A12-filtered scanline IRQ.
// Define MMC3_SS_EN to build the save-state register port; otherwise ss_dout reads $FF.
module mmc3_bank_irq_core #(
  parameter int unsigned PRG_BW      = 6,
  parameter int unsigned CHR_BW      = 8,
  parameter int unsigned CHR_RAM_BIT = 6,
  parameter int unsigned CHR_RAM_BW  = 3,
  parameter int unsigned A12_LOW_CYC = 3
) (
  input  logic              m2,
  input  logic              map_rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic              cpu_rw,
  input  logic [13:0]       ppu_addr,
  input  logic              cfg_mir_v,
  input  logic              cfg_chr_ram,
  input  logic              mmc3a,
  output logic [PRG_BW-1:0] prg_bank,
  output logic [CHR_BW-1:0] chr_bank,
  output logic              chr_ram_sel,
  output logic              ciram_a10,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              irq,
  input  logic              ss_act,
  input  logic              ss_we,
  input  logic [7:0]        ss_addr,
  output logic [7:0]        ss_dout
);

  localparam int unsigned A12_W = $clog2(A12_LOW_CYC + 1);
  localparam logic [A12_W-1:0] A12_SAT = A12_W'(A12_LOW_CYC);

  logic [7:0]       bank_sel;
  logic [7:0]       bank_dat [8];
  logic             mirroring;
  logic             ram_en;
  logic             ram_wp;
  logic [7:0]       irq_latch;
  logic [7:0]       irq_cnt;
  logic             irq_reload;
  logic             irq_en;
  logic [A12_W-1:0] a12_cnt;

  logic             ss_blk_c;
  logic [3:0]       reg_sel_c;
  logic             cpu_we_c;
  logic             c001_we_c;
  logic             a12_evt_c;
  logic [7:0]       cnt_new_c;
  logic             irq_fire_c;
  logic             chr_half_c;
  logic [2:0]       chr_idx_c;
  logic [7:0]       chr_val_c;
  logic             chr_ovl_c;
  logic             unused_bits;

  // CPU register write decode on {A15:A13, A0}
  always_comb begin
`ifdef MMC3_SS_EN
    ss_blk_c = ss_act;
`else
    ss_blk_c = 1'b0;
`endif
    reg_sel_c = {cpu_addr[15:13], cpu_addr[0]};
    cpu_we_c  = !cpu_rw && cpu_addr[15] && !ss_blk_c;
    c001_we_c = cpu_we_c && (reg_sel_c == 4'b1101);
  end

  // A12 clock event and next counter value
  always_comb begin
    a12_evt_c  = ppu_addr[12] && (a12_cnt == A12_SAT);
    cnt_new_c  = ((irq_cnt == 8'd0) || irq_reload) ? irq_latch : irq_cnt - 8'd1;
    irq_fire_c = a12_evt_c && irq_en && !c001_we_c && (cnt_new_c == 8'd0) &&
                 (!mmc3a || (irq_cnt != 8'd0) || irq_reload);
  end

  // Register file, A12 filter and IRQ counter; later assignments take priority
  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      bank_sel    <= 8'd0;
      bank_dat[0] <= 8'd0;
      bank_dat[1] <= 8'd2;
      bank_dat[2] <= 8'd4;
      bank_dat[3] <= 8'd5;
      bank_dat[4] <= 8'd6;
      bank_dat[5] <= 8'd7;
      bank_dat[6] <= 8'd0;
      bank_dat[7] <= 8'd1;
      mirroring   <= !cfg_mir_v;
      ram_en      <= 1'b0;
      ram_wp      <= 1'b0;
      irq_latch   <= 8'd0;
      irq_cnt     <= 8'd0;
      irq_reload  <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      a12_cnt     <= A12_SAT;
    end else begin
      if (ppu_addr[12]) begin
        a12_cnt <= '0;
      end else if (a12_cnt != A12_SAT) begin
        a12_cnt <= a12_cnt + A12_W'(1);
      end

      if (a12_evt_c) begin
        irq_cnt    <= cnt_new_c;
        irq_reload <= 1'b0;
      end
      if (irq_fire_c) begin
        irq <= 1'b1;
      end

      if (cpu_we_c) begin
        case (reg_sel_c)
          4'b1000: bank_sel <= cpu_dat;
          4'b1001: bank_dat[bank_sel[2:0]] <= cpu_dat;
          4'b1010: mirroring <= cpu_dat[0];
          4'b1011: begin
            ram_en <= cpu_dat[7];
            ram_wp <= cpu_dat[6];
          end
          4'b1100: irq_latch <= cpu_dat;
          4'b1101: begin
            irq_cnt    <= 8'd0;
            irq_reload <= 1'b1;
          end
          4'b1110: begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
          end
          4'b1111: irq_en <= 1'b1;
          default: ;
        endcase
      end

`ifdef MMC3_SS_EN
      // save-state write data rides on cpu_dat
      if (ss_act && ss_we) begin
        if (ss_addr[7:3] == 5'd0) begin
          bank_dat[ss_addr[2:0]] <= cpu_dat;
        end else begin
          case (ss_addr)
            8'd8:  bank_sel <= cpu_dat;
            8'd9:  mirroring <= cpu_dat[0];
            8'd10: begin
              ram_en <= cpu_dat[7];
              ram_wp <= cpu_dat[6];
            end
            8'd16: irq_latch <= cpu_dat;
            8'd17: irq_cnt <= cpu_dat;
            8'd18: begin
              irq_reload <= cpu_dat[2];
              irq_en     <= cpu_dat[1];
              irq        <= cpu_dat[0];
            end
            default: ;
          endcase
        end
      end
`endif
    end
  end

  // PRG bank select; the fixed banks are the last two of the PRG space
  always_comb begin
    prg_bank = '1;
    case (cpu_addr[14:13])
      2'd0:    prg_bank = bank_sel[6] ? ~PRG_BW'(1) : PRG_BW'(bank_dat[6]);
      2'd1:    prg_bank = PRG_BW'(bank_dat[7]);
      2'd2:    prg_bank = bank_sel[6] ? PRG_BW'(bank_dat[6]) : ~PRG_BW'(1);
      default: prg_bank = '1;
    endcase
  end

  // Selected CHR bank value; the 2K half takes its LSB from PPU A10
  always_comb begin
    chr_half_c = ppu_addr[12] ^ bank_sel[7];
    chr_idx_c  = chr_half_c ? ({1'b0, ppu_addr[11:10]} + 3'd2) : {2'b00, ppu_addr[11]};
    chr_val_c  = bank_dat[chr_idx_c];
    if (!chr_half_c) begin
      chr_val_c[0] = ppu_addr[10];
    end
  end

  generate
    if (CHR_RAM_BIT < 8) begin : g_ovl
      assign chr_ovl_c = chr_val_c[CHR_RAM_BIT];
    end else begin : g_no_ovl
      assign chr_ovl_c = 1'b0;
    end
  endgenerate

  always_comb begin
    chr_ram_sel = cfg_chr_ram | chr_ovl_c;
    chr_bank    = CHR_BW'(chr_val_c);
    if (!cfg_chr_ram && chr_ovl_c) begin
      chr_bank = CHR_BW'(chr_val_c[CHR_RAM_BW-1:0]);
    end
  end

  assign ciram_a10 = mirroring ? ppu_addr[11] : ppu_addr[10];
  assign ram_ce    = (cpu_addr[15:13] == 3'b011) && ram_en;
  assign ram_we    = ram_ce && !cpu_rw && !ram_wp;

  // Save-state readback
  always_comb begin
    ss_dout = 8'hFF;
`ifdef MMC3_SS_EN
    if (ss_addr[7:3] == 5'd0) begin
      ss_dout = bank_dat[ss_addr[2:0]];
    end else begin
      case (ss_addr)
        8'd8:    ss_dout = bank_sel;
        8'd9:    ss_dout = {7'd0, mirroring};
        8'd10:   ss_dout = {ram_en, ram_wp, 6'd0};
        8'd16:   ss_dout = irq_latch;
        8'd17:   ss_dout = irq_cnt;
        8'd18:   ss_dout = {5'd0, irq_reload, irq_en, irq};
        default: ss_dout = 8'hFF;
      endcase
    end
`endif
  end

`ifdef MMC3_SS_EN
  assign unused_bits = ^{cpu_addr[12:1], ppu_addr[13]};
`else
  assign unused_bits = ^{cpu_addr[12:1], ppu_addr[13], ss_act, ss_we, ss_addr};
`endif

endmodule
